perf_stats_reader: RTL and testbench
====================================

// Module: perf_stats_reader
// PURPOSE
//  Downstream consumer of the NPU performance counter block. On a snapshot request it
//  latches all raw counters atomically, derives avg-compute-cycles and utilization with
//  one shared multi-cycle restoring divider (no combinational dividers), and serves all
//  values through a registered 8-entry read port for host/CSR access.
// PARAMETERS
//  COUNTER_WIDTH  32  width W of every counter input, snapshot register and derived result
// PORTS
//  clk               in   1   clock
//  rst_n             in   1   asynchronous reset, active-low
//  in_total_cycles   in   W   live counter values from the performance counter
//  in_compute_cycles in   W
//  in_idle_cycles    in   W
//  in_total_mac_ops  in   W
//  in_num_comps      in   W
//  snap_req          in   1   request snapshot + derive; sampled only in IDLE
//  snap_busy         out  1   high while FSM is not IDLE
//  snap_done         out  1   1-cycle pulse when derived results are updated
//  rd_en             in   1   register read strobe
//  rd_addr           in   3   register index (map below)
//  rd_data           out  32  read data; zero-extended or truncated to 32 bits
//  rd_valid          out  1   high the cycle after rd_en
// BEHAVIOUR
//  Reset: all snapshot regs, avg, util, flags, rd_data = 0; snap_busy, snap_done,
//   rd_valid, stats_valid = 0; FSM = IDLE. Reset mid-derivation aborts with no snap_done.
//  FSM: IDLE -> DIV_AVG -> DIV_UTIL -> DONE -> IDLE.
//   IDLE: if snap_req, at that edge load all 5 snapshot regs from inputs, clear
//    stats_valid, enter DIV_AVG. snap_req outside IDLE is ignored (not queued).
//   DIV_AVG: W cycles; restoring divide snap_compute / snap_num, one quotient bit/cycle.
//   DIV_UTIL: W+7 cycles; dividend = snap_compute*100 (W+7 bits), divisor = snap_total.
//   DONE: 1 cycle; write avg and util, snap_done=1, stats_valid=1; next IDLE.
//  Latency: snap_req sampled at edge 0 -> snap_done high in cycle 2W+8 (72 for W=32).
//  Timing is fixed: divisor 0 still consumes full cycle count; result forced 0 and
//   div0 flag set (avg_div0 for snap_num==0, util_div0 for snap_total==0).
//  util saturates to 100 if the quotient exceeds 100 (inconsistent counter wrap).
//  Divider state is internal; avg/util registers hold the previous result until DONE.
//  Read port: rd_en at edge k -> rd_data/rd_valid valid in cycle k+1; rd_valid=0 otherwise;
//   rd_data holds last value when rd_en=0. Reads allowed at any time, including busy.
//   addr 0 total_cycles, 1 compute_cycles, 2 idle_cycles, 3 total_mac_ops,
//   4 num_comps, 5 avg_compute_cycles, 6 utilization (0..100),
//   7 status {28'b0, util_div0, avg_div0, snap_busy, stats_valid}.
//  Addresses 0-4 return snapshot regs (new values visible from the cycle after accept);
//   5-6 return the last completed derivation; status reflects current state.
//  snap_req and rd_en in the same cycle: both serviced; rd_data for 0-4 shows pre-load value.
// TESTING
//  Reset then read addr 0..7 -> all rd_data = 0, rd_valid one cycle after each rd_en.
//  total=1000, compute=750, num=3; snap_req -> snap_done at cycle 72; avg=250, util=75,
//   status=4'b0001.
//  num=0, total=0, compute=0; snap_req -> snap_done at cycle 72; avg=0, util=0,
//   status=4'b1101.
//  compute=500, total=400 -> util saturates to 100; avg=compute/num exact.
//  snap_req pulsed at cycle 10 of busy -> ignored, single snap_done; inputs changed
//   after accept do not alter snapshot read at addr 0-4.
//  rst_n low at cycle 40 of derivation -> no snap_done, all outputs 0; new snap works.

Source files
------------

// File: rtl/perf_stats_reader.sv
// Snapshots the NPU performance counters and derives avg compute cycles and utilization
// through one shared restoring divider; every value is served by a registered 8-entry read port.
module perf_stats_reader #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COUNTER_WIDTH-1:0] in_total_cycles,
  input  logic [COUNTER_WIDTH-1:0] in_compute_cycles,
  input  logic [COUNTER_WIDTH-1:0] in_idle_cycles,
  input  logic [COUNTER_WIDTH-1:0] in_total_mac_ops,
  input  logic [COUNTER_WIDTH-1:0] in_num_comps,
  input  logic                     snap_req,
  output logic                     snap_busy,
  output logic                     snap_done,
  input  logic                     rd_en,
  input  logic [2:0]               rd_addr,
  output logic [31:0]              rd_data,
  output logic                     rd_valid
);

  localparam int W  = COUNTER_WIDTH;
  localparam int DW = W + 7;
  localparam int CW = $clog2(DW + 1);
  localparam int XW = (W > 32) ? W : 32;

  typedef enum logic [1:0] {S_IDLE, S_DIV_AVG, S_DIV_UTIL, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   snap_total, snap_compute, snap_idle, snap_mac, snap_num;
  logic [W-1:0]   avg_res, util_res, avg_tmp;
  logic           avg_div0, util_div0, stats_valid;
  logic [DW-1:0]  dvd, dvd_nxt, mul100;
  logic [W-1:0]   rem, rem_nxt, divisor, util_sat;
  logic [W:0]     trial;
  logic           q_bit;
  logic [CW-1:0]  cnt;
  logic [31:0]    rd_mux;

  function automatic logic [31:0] ext32(input logic [W-1:0] v);
    logic [XW-1:0] t;
    t = XW'(v);
    return t[31:0];
  endfunction

  // The dividend register doubles as the quotient: result bits shift in at the LSB.
  assign divisor = (state == S_DIV_AVG) ? snap_num : snap_total;
  assign trial   = {rem, dvd[DW-1]};
  assign q_bit   = (trial >= {1'b0, divisor});
  assign rem_nxt = q_bit ? W'(trial - {1'b0, divisor}) : trial[W-1:0];
  assign dvd_nxt = {dvd[DW-2:0], q_bit};
  assign mul100  = DW'(snap_compute) * DW'(100);
  assign util_sat = (dvd > DW'(100)) ? W'(100) : dvd[W-1:0];
  assign snap_busy = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (snap_req) state_nxt = S_DIV_AVG;
      S_DIV_AVG:  if (cnt == CW'(W - 1)) state_nxt = S_DIV_UTIL;
      S_DIV_UTIL: if (cnt == CW'(DW - 1)) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      snap_total   <= '0;
      snap_compute <= '0;
      snap_idle    <= '0;
      snap_mac     <= '0;
      snap_num     <= '0;
      avg_res      <= '0;
      util_res     <= '0;
      avg_tmp      <= '0;
      avg_div0     <= 1'b0;
      util_div0    <= 1'b0;
      stats_valid  <= 1'b0;
      snap_done    <= 1'b0;
      dvd          <= '0;
      rem          <= '0;
      cnt          <= '0;
    end else begin
      state     <= state_nxt;
      snap_done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (snap_req) begin
            snap_total   <= in_total_cycles;
            snap_compute <= in_compute_cycles;
            snap_idle    <= in_idle_cycles;
            snap_mac     <= in_total_mac_ops;
            snap_num     <= in_num_comps;
            stats_valid  <= 1'b0;
            dvd          <= {in_compute_cycles, 7'b0};
            rem          <= '0;
            cnt          <= '0;
          end
        end
        S_DIV_AVG: begin
          if (cnt == CW'(W - 1)) begin
            avg_tmp <= dvd_nxt[W-1:0];
            dvd     <= mul100;
            rem     <= '0;
            cnt     <= '0;
          end else begin
            dvd <= dvd_nxt;
            rem <= rem_nxt;
            cnt <= cnt + 1'b1;
          end
        end
        S_DIV_UTIL: begin
          dvd <= dvd_nxt;
          rem <= rem_nxt;
          cnt <= cnt + 1'b1;
        end
        S_DONE: begin
          // Zero divisors still run the full schedule; the garbage quotient is discarded here.
          avg_div0    <= (snap_num == '0);
          util_div0   <= (snap_total == '0);
          avg_res     <= (snap_num == '0) ? '0 : avg_tmp;
          util_res    <= (snap_total == '0) ? '0 : util_sat;
          stats_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      3'd0: rd_mux = ext32(snap_total);
      3'd1: rd_mux = ext32(snap_compute);
      3'd2: rd_mux = ext32(snap_idle);
      3'd3: rd_mux = ext32(snap_mac);
      3'd4: rd_mux = ext32(snap_num);
      3'd5: rd_mux = ext32(avg_res);
      3'd6: rd_mux = ext32(util_res);
      3'd7: rd_mux = {28'b0, util_div0, avg_div0, snap_busy, stats_valid};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_perf_stats_reader.sv
// Directed bench for perf_stats_reader: reset state, derivations, div-by-zero, saturation,
// busy-time request rejection, same-cycle read/accept, and reset abort.
module tb_perf_stats_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_total_cycles = '0, in_compute_cycles = '0, in_idle_cycles = '0;
  logic [31:0] in_total_mac_ops = '0, in_num_comps = '0;
  logic        snap_req = 1'b0;
  logic        snap_busy, snap_done;
  logic        rd_en = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_valid;

  int checks = 0;
  int errors = 0;

  perf_stats_reader #(.COUNTER_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_total_cycles(in_total_cycles), .in_compute_cycles(in_compute_cycles),
    .in_idle_cycles(in_idle_cycles), .in_total_mac_ops(in_total_mac_ops),
    .in_num_comps(in_num_comps),
    .snap_req(snap_req), .snap_busy(snap_busy), .snap_done(snap_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic do_read(input logic [2:0] a, output logic [31:0] d, output logic v);
    rd_en = 1'b1;
    rd_addr = a;
    @(posedge clk); #1;
    rd_en = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  task automatic set_inputs(input logic [31:0] t, c, i, m, n);
    in_total_cycles = t; in_compute_cycles = c; in_idle_cycles = i;
    in_total_mac_ops = m; in_num_comps = n;
  endtask

  task automatic start_snap();
    snap_req = 1'b1;
    @(posedge clk); #1;
    snap_req = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (snap_done) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    checks++;
    if (snap_busy !== 1'b0 || snap_done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b valid=%b data=%0d, required all 0",
               snap_busy, snap_done, rd_valid, rd_data);
    end
    for (int a = 0; a < 8; a++) begin
      do_read(3'(a), d, v);
      checks++;
      if (d !== 32'd0 || v !== 1'b1) begin
        errors++;
        $display("FAIL reset_read[%0d]: data=%0d valid=%b, required data=0 valid=1", a, d, v);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_valid_idle: got %b, required 0", rd_valid);
    end
  endtask

  task automatic check_snapshot(input string name, input logic [31:0] exp [8]);
    logic [31:0] d;
    logic v;
    for (int a = 0; a < 8; a++) begin
      do_read(3'(a), d, v);
      checks++;
      if (d !== exp[a] || v !== 1'b1) begin
        errors++;
        $display("FAIL %s addr%0d: data=%0d valid=%b, required data=%0d valid=1", name, a, d, v, exp[a]);
      end
    end
  endtask

  task automatic run_case(input string name, input logic [31:0] t, c, i, m, n,
                          input logic [31:0] avg, util, status);
    int lat;
    logic [31:0] exp [8];
    set_inputs(t, c, i, m, n);
    start_snap();
    wait_done(lat);
    checks++;
    if (lat != 72) begin
      errors++;
      $display("FAIL %s latency: snap_done at cycle %0d, required 72 (0 = timeout)", name, lat);
    end
    exp = '{t, c, i, m, n, avg, util, status};
    check_snapshot(name, exp);
  endtask

  task automatic test_basic();
    run_case("basic", 32'd1000, 32'd750, 32'd250, 32'd12345, 32'd3, 32'd250, 32'd75, 32'd1);
  endtask

  task automatic test_div0();
    run_case("div0", 32'd0, 32'd0, 32'd7, 32'd9, 32'd0, 32'd0, 32'd0, 32'd13);
  endtask

  task automatic test_saturate();
    run_case("saturate", 32'd400, 32'd500, 32'd0, 32'd64, 32'd7, 32'd71, 32'd100, 32'd1);
  endtask

  task automatic test_busy_ignore();
    int dones = 0;
    int first = 0;
    logic [31:0] d;
    logic v;
    logic [31:0] exp [8];
    set_inputs(32'd2000, 32'd1000, 32'd5, 32'd6, 32'd4);
    // Read addr 0 in the accept cycle: must return the pre-load snapshot (400).
    rd_en = 1'b1; rd_addr = 3'd0; snap_req = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0; snap_req = 1'b0;
    checks++;
    if (rd_data !== 32'd400 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_read: data=%0d valid=%b, required 400 valid=1", rd_data, rd_valid);
    end
    set_inputs(32'd9, 32'd9, 32'd9, 32'd9, 32'd9);
    for (int c = 1; c <= 150; c++) begin
      @(posedge clk); #1;
      if (snap_done) begin
        dones++;
        if (first == 0) first = c;
      end
      snap_req = (c == 10);
      if (c == 20) begin
        rd_en = 1'b1; rd_addr = 3'd7;
      end else if (c == 21) begin
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 32'd2 || rd_valid !== 1'b1) begin
          errors++;
          $display("FAIL busy_status: data=%0d valid=%b, required 2 valid=1", rd_data, rd_valid);
        end
      end
    end
    checks++;
    if (dones != 1 || first != 72) begin
      errors++;
      $display("FAIL busy_ignore: %0d done pulses first at %0d, required 1 at 72", dones, first);
    end
    exp = '{32'd2000, 32'd1000, 32'd5, 32'd6, 32'd4, 32'd250, 32'd50, 32'd1};
    check_snapshot("busy_ignore", exp);
  endtask

  task automatic test_reset_abort();
    int lat;
    logic [31:0] exp [8];
    set_inputs(32'd300, 32'd150, 32'd1, 32'd2, 32'd5);
    start_snap();
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (snap_busy !== 1'b0 || snap_done !== 1'b0 || rd_data !== 32'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: busy=%b done=%b data=%0d valid=%b, required all 0",
               snap_busy, snap_done, rd_data, rd_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_done(lat);
    checks++;
    if (lat != 0) begin
      errors++;
      $display("FAIL abort_no_done: snap_done seen at cycle %0d, required none", lat);
    end
    exp = '{default: 32'd0};
    check_snapshot("abort_regs", exp);
    run_case("after_abort", 32'd100, 32'd40, 32'd60, 32'd8, 32'd2, 32'd20, 32'd40, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_div0();
    test_saturate();
    test_busy_ignore();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
